// File: rtl/aes_pkg.sv
// Shared AES widths and byte-index type for the block/byte converters.
package aes_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int AES_BYT_W   = 8;
  localparam int AES_NUM_BYT = 16;
  localparam int AES_IDX_W   = 4;

  // Byte index k = {col[1:0], row[1:0]} within an AES state block.
  typedef logic [AES_IDX_W-1:0] aes_byt_idx_t;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } aes_ser_state_e;

  localparam aes_byt_idx_t AES_LAST_IDX = aes_byt_idx_t'(AES_NUM_BYT - 1);

endpackage : aes_pkg

// File: rtl/aes_block_serializer.sv
// AES block serializer: accepts a 128-bit state block and streams it out
// one byte per handshake, byte k=0 (MSB byte) first through k=15.
// Optional macro AES_SER_DBUF_EN adds a one-block holding buffer so that
// back-to-back blocks stream with no idle cycle between them.
module aes_block_serializer
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_BLK_W-1:0] blk_in,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic [AES_BYT_W-1:0] byt_out,
  output logic                 byt_valid,
  input  logic                 byt_ready,
  output logic [AES_IDX_W-1:0] byt_idx,
  output logic                 byt_last,
  output logic                 busy
);

  aes_ser_state_e       state_q, state_d;
  logic [AES_BLK_W-1:0] sh_q, sh_d;
  aes_byt_idx_t         cnt_q, cnt_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;

  logic                 blk_acc_s;
  logic                 byt_acc_s;
  aes_byt_idx_t         cnt_inc_s;

`ifdef AES_SER_DBUF_EN
  logic [AES_BLK_W-1:0] buf_q, buf_d;
  logic                 buf_v_q, buf_v_d;

  // The buffer is the only thing that can refuse a block.
  assign blk_ready = ~buf_v_q;
  assign busy      = (state_q == SEND) | buf_v_q;
`else
  // Without a buffer a block can only be taken while nothing is streaming.
  assign blk_ready = (state_q == IDLE);
  assign busy      = (state_q == SEND);
`endif

  assign blk_acc_s = blk_valid & blk_ready;
  assign byt_acc_s = vld_q & byt_ready;
  assign cnt_inc_s = cnt_q + 4'd1;

  // Outputs come straight from registers so they hold steady under backpressure.
  assign byt_out   = sh_q[AES_BLK_W-1 -: AES_BYT_W];
  assign byt_idx   = cnt_q;
  assign byt_valid = vld_q;
  assign byt_last  = last_q;

  // Next-state logic: load, shift, end of block and (optionally) buffering.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    last_d  = last_q;
`ifdef AES_SER_DBUF_EN
    buf_d   = buf_q;
    buf_v_d = buf_v_q;
`endif

    case (state_q)
      IDLE: begin
        if (blk_acc_s) begin
          state_d = SEND;
          sh_d    = blk_in;
          cnt_d   = 4'd0;
          vld_d   = 1'b1;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (byt_acc_s) begin
          if (cnt_q == AES_LAST_IDX) begin
`ifdef AES_SER_DBUF_EN
            // Chain the next block in directly so byte 0 follows with no bubble.
            if (buf_v_q) begin
              state_d = SEND;
              sh_d    = buf_q;
              cnt_d   = 4'd0;
              vld_d   = 1'b1;
              last_d  = 1'b0;
              buf_v_d = 1'b0;
            end else if (blk_acc_s) begin
              state_d = SEND;
              sh_d    = blk_in;
              cnt_d   = 4'd0;
              vld_d   = 1'b1;
              last_d  = 1'b0;
            end else begin
              state_d = IDLE;
              sh_d    = '0;
              cnt_d   = 4'd0;
              vld_d   = 1'b0;
              last_d  = 1'b0;
            end
`else
            state_d = IDLE;
            sh_d    = '0;
            cnt_d   = 4'd0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
`endif
          end else begin
            sh_d   = {sh_q[AES_BLK_W-AES_BYT_W-1:0], 8'h00};
            cnt_d  = cnt_inc_s;
            last_d = (cnt_inc_s == AES_LAST_IDX);
`ifdef AES_SER_DBUF_EN
            if (blk_acc_s) begin
              buf_d   = blk_in;
              buf_v_d = 1'b1;
            end else begin
              buf_v_d = buf_v_q;
            end
`endif
          end
        end else begin
`ifdef AES_SER_DBUF_EN
          if (blk_acc_s) begin
            buf_d   = blk_in;
            buf_v_d = 1'b1;
          end else begin
            buf_v_d = buf_v_q;
          end
`else
          state_d = SEND;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = 4'd0;
        vld_d   = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that drops any block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= 4'd0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

`ifdef AES_SER_DBUF_EN
  // Holding buffer for a block accepted while the previous one streams.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      buf_v_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      buf_v_q <= buf_v_d;
    end
  end
`endif

endmodule : aes_block_serializer

// File: tb/tb_aes_block_serializer.sv
// Directed self-checking bench for aes_block_serializer.
module tb_aes_block_serializer;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] blk_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [7:0]   byt_out;
  logic         byt_valid;
  logic         byt_ready;
  logic [3:0]   byt_idx;
  logic         byt_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B2 = 128'hffeeddccbbaa99887766554433221100;

`ifdef AES_SER_DBUF_EN
  localparam logic RDY_STREAM = 1'b1;
`else
  localparam logic RDY_STREAM = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_block_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .blk_in    (blk_in),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .byt_out   (byt_out),
    .byt_valid (byt_valid),
    .byt_ready (byt_ready),
    .byt_idx   (byt_idx),
    .byt_last  (byt_last),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input int k, input logic [7:0] eb);
    chk({tag, "_valid"}, 32'(byt_valid), 32'd1);
    chk({tag, "_out"},   32'(byt_out),   32'(eb));
    chk({tag, "_idx"},   32'(byt_idx),   32'(k));
    chk({tag, "_last"},  32'(byt_last),  32'(k == 15));
    chk({tag, "_busy"},  32'(busy),      32'd1);
  endtask

  // Consume bytes from..to of blk, one per cycle, checking each.
  task automatic drain(input string tag, input logic [127:0] blk, input int from, input int to);
    logic [127:0] b;
    b = blk;
    for (int k = from; k <= to; k++) begin
      chk_byte(tag, k, b[127 - 8*k -: 8]);
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(byt_valid), 32'd0);
    chk({tag, "_last"},  32'(byt_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_rdy"},   32'(blk_ready), 32'd1);
  endtask

  task automatic load(input logic [127:0] blk);
    blk_in    = blk;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    blk_in    = '0;
    blk_valid = 1'b0;
    byt_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out",   32'(byt_out),   32'd0);
    chk("rst_idx",   32'(byt_idx),   32'd0);
    chk("rst_valid", 32'(byt_valid), 32'd0);
    chk("rst_last",  32'(byt_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst = 1'b0;
    step();
    chk("rst_rdy",   32'(blk_ready), 32'd1);

    // Plain stream with byt_ready held high
    byt_ready = 1'b1;
    load(B1);
    chk("s1_rdy", 32'(blk_ready), 32'(RDY_STREAM));
    drain("s1", B1, 0, 15);
    chk_idle("s1_end");

    // Backpressure for three cycles on byte 5
    load(B1);
    drain("bp", B1, 0, 4);
    byt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_byte("bp_hold", 5, 8'h55);
      step();
    end
    byt_ready = 1'b1;
    drain("bp", B1, 5, 15);
    chk_idle("bp_end");

    // Second block offered while the first streams
    blk_in    = B1;
    blk_valid = 1'b1;
    step();
    blk_in    = B2;
`ifdef AES_SER_DBUF_EN
    chk("bb_rdy0", 32'(blk_ready), 32'd1);
    drain("bb1", B1, 0, 0);
    blk_valid = 1'b0;
    chk("bb_busy", 32'(busy), 32'd1);
    drain("bb1", B1, 1, 15);
`else
    for (int k = 0; k < 16; k++) begin
      chk("bb_stall", 32'(blk_ready), 32'd0);
      drain("bb1", B1, k, k);
    end
    chk_idle("bb_gap");
    step();
    blk_valid = 1'b0;
`endif
    drain("bb2", B2, 0, 15);
    chk_idle("bb_end");

    // Reset in the middle of a block
    load(B1);
    drain("mr", B1, 0, 5);
    rst = 1'b1;
    step();
    chk("mr_out",   32'(byt_out),   32'd0);
    chk("mr_idx",   32'(byt_idx),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle("mr_quiet");
      step();
    end
    load(B2);
    drain("mr2", B2, 0, 15);
    chk_idle("mr2_end");

    // Consumer stalled from byte 0, single blk_valid pulse
    byt_ready = 1'b0;
    load(B2);
    for (int i = 0; i < 8; i++) begin
      chk_byte("st_hold", 0, 8'hff);
      step();
    end
    byt_ready = 1'b1;
    drain("st", B2, 0, 15);
    chk_idle("st_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_aes_block_serializer

// File: doc/aes_block_serializer.md
AES_BLOCK_SERIALIZER -- requirements
Module: aes_block_serializer

Interface
REQ-001 The block SHALL have no parameters; widths come from aes_pkg (AES_BLK_W=128, AES_BYT_W=8, AES_NUM_BYT=16).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 blk_in  in  128  AES state block; byte k=4*col+row at bits [127-8k : 120-8k].
REQ-005 blk_valid  in  1  blk_in is valid.
REQ-006 blk_ready  out  1  block accepted when blk_valid && blk_ready.
REQ-007 byt_out  out  8  current serialized byte.
REQ-008 byt_valid  out  1  byt_out is valid.
REQ-009 byt_ready  in  1  byte consumed when byt_valid && byt_ready.
REQ-010 byt_idx  out  4  {col[1:0],row[1:0]} of byt_out, equal to k.
REQ-011 byt_last  out  1  high with byt_valid on byte k=15.
REQ-012 busy  out  1  a block is loaded or being streamed.

Function
REQ-013 States SHALL be IDLE and SEND; IDLE->SEND on block accept, SEND->IDLE on acceptance of byte 15 with no next block available.
REQ-014 Byte order SHALL be k=0..15 (row fastest within a column, then column), i.e. the MSB byte of blk_in first.
REQ-015 On accept, blk_in SHALL be registered into a 128-bit shift register and the byte counter cleared; byt_valid SHALL assert the following cycle (latency 1).
REQ-016 byt_out, byt_idx and byt_last SHALL be register-driven and held stable while byt_valid && !byt_ready.
REQ-017 On each byte handshake the shift register SHALL shift left 8 bits and the 4-bit counter increment; counter reaching 15 and accepting SHALL end the block (no wrap into a 17th byte).
REQ-018 byt_valid SHALL stay asserted continuously from byte 0 through byte 15 (no gaps inside a block).
REQ-019 Without the buffer option, blk_ready SHALL equal (state==IDLE); a block presented while busy SHALL stall, not be dropped.
REQ-020 busy SHALL be high in SEND and low in IDLE (plus buffer occupancy when enabled).

Reset
REQ-021 When rst is high at a clock edge: state=IDLE, counter=0, shift register=0, byt_valid=0, byt_last=0, byt_idx=0, byt_out=0, busy=0; blk_ready=1 from the following cycle.
REQ-022 Reset mid-block SHALL discard the block and remaining bytes; no byt_last SHALL be emitted for it.

Configuration
REQ-023 Macro AES_SER_DBUF_EN SHALL add one 128-bit holding buffer with a valid flag.
REQ-024 With AES_SER_DBUF_EN: blk_ready = !buf_valid; a block accepted in SEND goes to the buffer; on acceptance of byte 15 a buffered block (or a block accepted in that same cycle when the buffer is empty) SHALL load directly, giving byte 0 of the next block the next cycle with zero bubble.
REQ-025 Without AES_SER_DBUF_EN: no buffer logic; one idle cycle minimum between blocks (byte 15 accept -> IDLE -> accept -> byte 0).

Structure
REQ-026 aes_pkg SHALL hold AES_BLK_W, AES_BYT_W, AES_NUM_BYT and the 4-bit byte-index type, shared with the block/byte converter.
REQ-027 The design SHALL be a single module; no sub-module.

Verification
REQ-028 Load 00112233445566778899aabbccddeeff, byt_ready=1 -> bytes 00,11,...,ff on 16 consecutive cycles, byt_idx 0..15, byt_last only with ff.
REQ-029 Same block, byt_ready low for 3 cycles at byte 5 -> byt_out=55, byt_idx=5 held 3 cycles, then stream resumes with 66.
REQ-030 Second block ffeeddccbbaa99887766554433221100 presented during streaming -> blk_ready=0 until IDLE (no DBUF); with DBUF accepted at once, ff follows 00... stream's ff on the next cycle.
REQ-031 rst asserted after byte 5 accepted -> next cycle all outputs 0, byt_valid=0, no byt_last; new block then streams from byte 0.
REQ-032 byt_ready=0 from start of block -> byte 0 held indefinitely; blk_valid toggling in IDLE without blk_ready interplay never produces a partial block.
